rng_scheduler: RTL and testbench

- Shares one free-running `lfsr_16` pseudo-random source among N_REQ game-logic requesters, such as the obstacle spawner, coin spawner and lane picker.
- Each requester asks for a uniform value in [0, bound). The block grants requesters round-robin and draws values by rejection sampling against the LFSR output.
- The block owns seeding: a fixed seed at reset, and a run-time reseed from a gameplay entropy source.

---
 rtl/rng_scheduler.sv | 174 +++++++++++++++++
 tb/tb_rng_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_scheduler.sv
// Round-robin shared random-number server: one free-running 16-bit LFSR,
// N_REQ requesters, uniform values in [0, bound) by masked rejection sampling.

module lfsr_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  // Galois form, taps 0x8005; a non-zero state never decays to zero.
  always_ff @(posedge clk) begin
    if (rst) q <= seed;
    else     q <= {q[14:0], 1'b0} ^ (q[15] ? 16'h8005 : 16'h0000);
  end
endmodule

// state | meaning
// IDLE  | waiting for a request; picks the round-robin winner
// DRAW  | sampling the LFSR until a value below bound is found (or fallback)
// DONE  | gnt_valid cycle; result presented for gnt_id
module rng_scheduler #(
  parameter int          N_REQ     = 4,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  reseed,
  input  logic [15:0]                           reseed_value,
  input  logic [N_REQ-1:0]                      req,
  input  logic [16*N_REQ-1:0]                   bound,
  output logic                                  gnt_valid,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] gnt_id,
  output logic [15:0]                           rnd,
  output logic                                  busy
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [4:0] TRY_LAST = 5'(MAX_TRIES - 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t        state;
  logic [IW-1:0] rr;
  logic [IW-1:0] id;
  logic [15:0]   b;
  logic [15:0]   mask;
  logic [4:0]    tries;

  logic          lfsr_rst;
  logic [15:0]   lfsr_seed;
  logic [15:0]   q;

  assign lfsr_rst  = rst | reseed;
  assign lfsr_seed = rst ? SEED : ((reseed_value == 16'd0) ? SEED : reseed_value);

  lfsr_16 u_lfsr (
    .clk  (clk),
    .rst  (lfsr_rst),
    .seed (lfsr_seed),
    .q    (q)
  );

  // Smallest all-ones value covering b-1; zero for b <= 1.
  function automatic logic [15:0] mask_for(input logic [15:0] bv);
    logic [15:0] x;
    if (bv <= 16'd1) return 16'd0;
    x = bv - 16'd1;
    x = x | (x >> 1);
    x = x | (x >> 2);
    x = x | (x >> 4);
    x = x | (x >> 8);
    return x;
  endfunction

  logic          win_found;
  logic [IW-1:0] win_id;
  logic [IW-1:0] rr_next;
  logic [15:0]   bound_sel;
  int            idx;

  // Scan downwards so the lowest offset from rr wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr) + k) % N_REQ;
      if (req[idx]) begin
        win_found = 1'b1;
        win_id    = IW'(idx);
      end
    end
  end

  assign rr_next   = (int'(win_id) == N_REQ - 1) ? '0 : win_id + IW'(1);
  assign bound_sel = bound[int'(win_id)*16 +: 16];

  logic [15:0] cand;
  logic        accept;
  logic [15:0] acc_val;

  assign cand = q & mask;

  // mask < 2b, so the fallback cand-b is always inside [0, b).
  always_comb begin
    accept  = 1'b1;
    acc_val = q;
    if (b == 16'd0) begin
      acc_val = q;
    end else if (cand < b) begin
      acc_val = cand;
    end else if (tries == TRY_LAST) begin
      acc_val = cand - b;
    end else begin
      accept  = 1'b0;
      acc_val = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= '0;
      id        <= '0;
      b         <= '0;
      mask      <= '0;
      tries     <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      rnd       <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          gnt_valid <= 1'b0;
          if (win_found) begin
            id    <= win_id;
            b     <= bound_sel;
            mask  <= mask_for(bound_sel);
            tries <= '0;
            rr    <= rr_next;
            busy  <= 1'b1;
            state <= DRAW;
          end
        end
        DRAW: begin
          // An abort hands the turn back to the same requester.
          if (reseed) begin
            rr    <= id;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (accept) begin
            rnd       <= acc_val;
            gnt_id    <= id;
            gnt_valid <= 1'b1;
            state     <= DONE;
          end else begin
            tries <= tries + 5'd1;
          end
        end
        DONE: begin
          gnt_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          gnt_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rng_scheduler.sv
// Bench for rng_scheduler: directed literal checks followed by randomized
// requests, reseeds and resets compared every cycle against a reference model.

module tb_rng_scheduler;
  localparam int          N    = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          MT   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        reseed;
  logic [15:0] reseed_value;
  logic [3:0]  req;
  logic [63:0] bound;
  logic        gnt_valid;
  logic [1:0]  gnt_id;
  logic [15:0] rnd;
  logic        busy;

  logic [3:0]  req_t;
  logic [63:0] bound_t;
  logic        gnt_valid_t;
  logic [1:0]  gnt_id_t;
  logic [15:0] rnd_t;
  logic        busy_t;

  rng_scheduler #(.N_REQ(N), .SEED(SEED), .MAX_TRIES(MT)) dut (
    .clk(clk), .rst(rst), .reseed(reseed), .reseed_value(reseed_value),
    .req(req), .bound(bound), .gnt_valid(gnt_valid), .gnt_id(gnt_id),
    .rnd(rnd), .busy(busy)
  );

  rng_scheduler #(.N_REQ(N), .SEED(SEED), .MAX_TRIES(1)) dut_t1 (
    .clk(clk), .rst(rst), .reseed(reseed), .reseed_value(reseed_value),
    .req(req_t), .bound(bound_t), .gnt_valid(gnt_valid_t), .gnt_id(gnt_id_t),
    .rnd(rnd_t), .busy(busy_t)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = waiting, 1 = drawing, 2 = presenting result.
  logic [15:0] m_q = '0;
  int          m_phase = 0;
  int          m_rr = 0;
  int          m_id = 0;
  int          m_tries = 0;
  logic [15:0] m_b = '0;
  logic [15:0] m_mask = '0;
  logic        m_gv = 1'b0;
  logic        m_busy = 1'b0;
  logic [1:0]  m_gid = '0;
  logic [15:0] m_rnd = '0;

  function automatic logic [15:0] next_q(input logic [15:0] v);
    logic [15:0] d;
    d = v << 1;
    if (v >= 16'h8000) d = d ^ 16'h8005;
    return d;
  endfunction

  function automatic logic [15:0] mask_of(input logic [15:0] bv);
    int m;
    int lim;
    if (bv <= 16'd1) return 16'd0;
    lim = int'(bv) - 1;
    m = 0;
    while (m < lim) m = m * 2 + 1;
    return 16'(m);
  endfunction

  task automatic model_step();
    logic [15:0] q_now;
    logic [15:0] cand;
    logic        found;
    int          w;
    if (rst) begin
      m_q = SEED; m_phase = 0; m_rr = 0; m_id = 0; m_tries = 0;
      m_gv = 1'b0; m_busy = 1'b0; m_gid = '0; m_rnd = '0;
      return;
    end
    q_now = m_q;
    if (m_phase == 0) begin
      found = 1'b0;
      w = 0;
      for (int k = 0; k < N; k++)
        if (!found && req[(m_rr + k) % N]) begin found = 1'b1; w = (m_rr + k) % N; end
      if (found) begin
        m_id = w; m_b = bound[w*16 +: 16]; m_mask = mask_of(m_b);
        m_tries = 0; m_rr = (w + 1) % N; m_phase = 1; m_busy = 1'b1;
      end
    end else if (m_phase == 1) begin
      if (reseed) begin
        m_phase = 0; m_busy = 1'b0; m_rr = m_id;
      end else begin
        cand = q_now & m_mask;
        found = 1'b1;
        if (m_b == 16'd0)            m_rnd = q_now;
        else if (cand < m_b)         m_rnd = cand;
        else if (m_tries == MT - 1)  m_rnd = cand - m_b;
        else begin found = 1'b0; m_tries++; end
        if (found) begin m_gid = 2'(m_id); m_gv = 1'b1; m_phase = 2; end
      end
    end else begin
      m_gv = 1'b0; m_busy = 1'b0; m_phase = 0;
    end
    m_q = reseed ? ((reseed_value == 16'd0) ? SEED : reseed_value) : next_q(q_now);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model advances on the edge, DUT is compared mid-cycle.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("gnt_valid", {15'd0, gnt_valid}, {15'd0, m_gv});
    chk("busy",      {15'd0, busy},      {15'd0, m_busy});
    chk("gnt_id",    {14'd0, gnt_id},    {14'd0, m_gid});
    chk("rnd",       rnd,                m_rnd);
  endtask

  task automatic reset2();
    rst = 1'b1; reseed = 1'b0; req = '0; req_t = '0;
    cycle(); cycle();
    chk("rst_gv",   {15'd0, gnt_valid}, 16'd0);
    chk("rst_busy", {15'd0, busy},      16'd0);
    chk("rst_rnd",  rnd,                16'd0);
    chk("rst_id",   {14'd0, gnt_id},    16'd0);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] pick_bound();
    case ($urandom_range(0, 7))
      0: return 16'd0;
      1: return 16'd1;
      2: return 16'd2;
      3: return 16'd3;
      4: return 16'd5;
      5: return 16'd17;
      6: return 16'd300;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; reseed = 1'b0; reseed_value = '0;
    req = '0; bound = '0; req_t = '0; bound_t = '0;

    // bound 0: raw LFSR value of the draw cycle.
    reset2();
    bound[15:0] = 16'd0; req = 4'b0001;
    cycle();
    chk("t1_busy", {15'd0, busy}, 16'd1);
    cycle();
    chk("t1_gv",  {15'd0, gnt_valid}, 16'd1);
    chk("t1_rnd", rnd, 16'hD9C7);
    chk("t1_id",  {14'd0, gnt_id}, 16'd0);
    req = '0; cycle();

    // bound 16: accepted on the first draw.
    reset2();
    bound[15:0] = 16'd16; req = 4'b0001;
    cycle(); cycle();
    chk("t2_gv",  {15'd0, gnt_valid}, 16'd1);
    chk("t2_rnd", rnd, 16'h0007);
    req = '0; cycle();

    // bound 5: one rejection; single-try instance falls back to 7-5.
    reset2();
    bound[15:0] = 16'd5; req = 4'b0001;
    bound_t[15:0] = 16'd5; req_t = 4'b0001;
    cycle(); cycle();
    chk("t3_gv_early", {15'd0, gnt_valid}, 16'd0);
    chk("t3_fb_gv",  {15'd0, gnt_valid_t}, 16'd1);
    chk("t3_fb_rnd", rnd_t, 16'd2);
    req_t = '0;
    cycle();
    chk("t3_gv",  {15'd0, gnt_valid}, 16'd1);
    chk("t3_rnd", rnd, 16'd3);
    req = '0; cycle();

    // Round robin with everyone requesting, bound 1.
    reset2();
    bound = {4{16'd1}}; req = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      repeat ((g == 0) ? 2 : 3) cycle();
      chk("rr_gv",  {15'd0, gnt_valid}, 16'd1);
      chk("rr_id",  {14'd0, gnt_id}, 16'(g % 4));
      chk("rr_rnd", rnd, 16'd0);
    end
    req = '0; cycle();

    // Zero reseed coincident with a grant decision.
    reset2();
    cycle(); cycle(); cycle();
    reseed = 1'b1; reseed_value = 16'd0; bound[15:0] = 16'd0; req = 4'b0001;
    cycle();
    reseed = 1'b0;
    cycle();
    chk("rs0_gv",  {15'd0, gnt_valid}, 16'd1);
    chk("rs0_rnd", rnd, 16'hACE1);
    req = '0; cycle();

    // Reseed while idle, then draw.
    reseed = 1'b1; reseed_value = 16'h1234;
    cycle();
    reseed = 1'b0; req = 4'b0001;
    cycle(); cycle();
    chk("rsi_rnd", rnd, 16'h2468);
    req = '0; cycle();

    // Reseed during DRAW aborts and re-serves the same requester.
    reset2();
    bound[47:32] = 16'd0; bound[63:48] = 16'd0; req = 4'b1100;
    cycle();
    reseed = 1'b1; reseed_value = 16'hBEEF;
    cycle();
    reseed = 1'b0;
    chk("abort_gv",   {15'd0, gnt_valid}, 16'd0);
    chk("abort_busy", {15'd0, busy}, 16'd0);
    cycle(); cycle();
    chk("abort_gv2", {15'd0, gnt_valid}, 16'd1);
    chk("abort_id",  {14'd0, gnt_id}, 16'd2);
    chk("abort_rnd", rnd, 16'hFDDB);
    req = '0; cycle();

    // rst mid-draw clears everything, including the round-robin pointer.
    reset2();
    bound[31:16] = 16'd5; bound[47:32] = 16'd0; req = 4'b0110;
    cycle(); cycle();
    chk("rd_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    cycle();
    chk("rd_gv",   {15'd0, gnt_valid}, 16'd0);
    chk("rd_busy0", {15'd0, busy}, 16'd0);
    rst = 1'b0;
    cycle(); cycle();
    chk("rd_gv_mid", {15'd0, gnt_valid}, 16'd0);
    cycle();
    chk("rd_gv2", {15'd0, gnt_valid}, 16'd1);
    chk("rd_id",  {14'd0, gnt_id}, 16'd1);
    chk("rd_rnd", rnd, 16'd3);
    req = '0; cycle();

    // Randomized traffic.
    reset2();
    for (int c = 0; c < 4000; c++) begin
      cycle();
      rst = ($urandom_range(0, 399) == 0);
      reseed = ($urandom_range(0, 24) == 0);
      reseed_value = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      if (gnt_valid && $urandom_range(0, 1) == 1) req[gnt_id] = 1'b0;
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 7) == 0) begin
          bound[i*16 +: 16] = pick_bound();
          req[i] = 1'b1;
        end
    end
    rst = 1'b0; reseed = 1'b0; req = '0;
    cycle(); cycle(); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
